ov7670_fifo_ctrl: RTL and testbench

Frame-capture sequencer for the OV7670 camera module's AL422B frame FIFO. On request it arms the FIFO write port for exactly one camera frame, bounded by VSYNC, and then drains the stored frame through the FIFO read port. Read data is presented as a byte stream with valid/ready backpressure. It sits between the camera GPIO pins and downstream pixel consumers (display/VGA or JTAG readout), replacing static tie-offs of the FIFO control pins.

---
 rtl/ov7670_fifo_pkg.sv | 28 ++
 rtl/ov7670_fifo_ctrl_vsync_sync_edge.sv | 31 +++
 rtl/ov7670_fifo_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ov7670_fifo_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_fifo_pkg.sv
// Shared types and default sizing for the OV7670 / AL422B frame-FIFO sequencer.
package ov7670_fifo_pkg;

    // Sequencer states: write side (ARM..WRITE), then read side (RRST..DONE).
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_ARM     = 4'd1,
        ST_WRST    = 4'd2,
        ST_WRITE   = 4'd3,
        ST_RRST    = 4'd4,
        ST_READ_HI = 4'd5,
        ST_READ_LO = 4'd6,
        ST_HOLD    = 4'd7,
        ST_DONE    = 4'd8
    } state_e;

    // Frame sizes in bytes for the RGB565 output formats.
    localparam int QVGA_RGB565_BYTES = 153600;  // 320 x 240 x 2
    localparam int VGA_RGB565_BYTES  = 614400;  // 640 x 480 x 2

    // Pointer-reset pulse lengths.
    localparam int DEF_WRST_CYCLES = 4;
    localparam int DEF_RRST_CYCLES = 4;

    // Width of the shared phase counter used in WRST and RRST.
    localparam int CYC_W = 16;

endpackage

// File: rtl/ov7670_fifo_ctrl_vsync_sync_edge.sv
// Two-flop synchronizer for the camera VSYNC pin plus a registered rising-edge
// detector. The rise output is high for one cycle, three clk25 edges after the
// pin rises; a third flop supplies the "previous" value so a short glitch can
// never produce two edges.
module vsync_sync_edge (
    input  logic clk25,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic sync1_r;
    logic sync2_r;
    logic sync3_r;

    // Synchronize the pin and register a single-cycle pulse on its rising edge.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync1_r <= async_in;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            rise    <= sync2_r & ~sync3_r;
        end
    end

endmodule

// File: rtl/ov7670_fifo_ctrl.sv
// Frame-capture sequencer for the OV7670 camera's AL422B frame FIFO.
// On capture_start it waits for VSYNC, resets the FIFO write pointer, enables
// writes for exactly one frame, then resets the read pointer and drains the
// frame byte by byte onto a valid/ready stream with sof/eof markers.
// Build option: define OV7670_FIFO_CTRL_CONTINUOUS_EN to re-arm after every
// frame (back-to-back capture, busy stays high until reset).
module ov7670_fifo_ctrl
    import ov7670_fifo_pkg::*;
#(
    parameter int FRAME_BYTES = QVGA_RGB565_BYTES,
    parameter int WRST_CYCLES = DEF_WRST_CYCLES,
    parameter int RRST_CYCLES = DEF_RRST_CYCLES
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       capture_start,
    input  logic       cam_vsync,
    input  logic [7:0] cam_data,
    output logic       cam_we,
    output logic       cam_wrst_n,
    output logic       cam_rrst_n,
    output logic       cam_oe_n,
    output logic       cam_rclk,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_sof,
    output logic       m_eof,
    output logic       busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(FRAME_BYTES);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);

    localparam logic [CYC_W-1:0] CYC_ZERO  = CYC_W'(0);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
    // WRST counts whole cycles; RRST counts half periods of cam_rclk.
    localparam logic [CYC_W-1:0] WRST_LAST = CYC_W'(WRST_CYCLES - 1);
    localparam logic [CYC_W-1:0] RRST_LAST = CYC_W'(2 * RRST_CYCLES - 1);

    state_e           state_r;
    logic [CYC_W-1:0] cyc_r;
    logic [CNT_W-1:0] byte_cnt_r;
    logic             vs_rise_s;

    vsync_sync_edge u_vsync (
        .clk25    (clk25),
        .reset_n  (reset_n),
        .async_in (cam_vsync),
        .rise     (vs_rise_s)
    );

    // Sequencer: every FIFO pin and stream output is a register set on the
    // transition into the state that needs it.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cyc_r      <= CYC_ZERO;
            byte_cnt_r <= CNT_ZERO;
            cam_we     <= 1'b0;
            cam_wrst_n <= 1'b1;
            cam_rrst_n <= 1'b1;
            cam_oe_n   <= 1'b1;
            cam_rclk   <= 1'b0;
            m_data     <= 8'h00;
            m_valid    <= 1'b0;
            m_sof      <= 1'b0;
            m_eof      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (capture_start) begin
                        busy    <= 1'b1;
                        state_r <= ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (vs_rise_s) begin
                        cam_wrst_n <= 1'b0;
                        cyc_r      <= CYC_ZERO;
                        state_r    <= ST_WRST;
                    end
                end
                ST_WRST: begin
                    if (cyc_r == WRST_LAST) begin
                        cam_wrst_n <= 1'b1;
                        cam_we     <= 1'b1;
                        state_r    <= ST_WRITE;
                    end else begin
                        cyc_r <= cyc_r + CYC_ONE;
                    end
                end
                ST_WRITE: begin
                    // The next frame start closes the write window; the read
                    // reset begins with cam_rclk high so it ends low.
                    if (vs_rise_s) begin
                        cam_we     <= 1'b0;
                        cam_oe_n   <= 1'b0;
                        cam_rrst_n <= 1'b0;
                        cam_rclk   <= 1'b1;
                        cyc_r      <= CYC_ZERO;
                        byte_cnt_r <= CNT_ZERO;
                        state_r    <= ST_RRST;
                    end
                end
                ST_RRST: begin
                    byte_cnt_r <= CNT_ZERO;
                    if (cyc_r == RRST_LAST) begin
                        cam_rrst_n <= 1'b1;
                        cam_rclk   <= 1'b1;
                        state_r    <= ST_READ_HI;
                    end else begin
                        cam_rclk <= ~cam_rclk;
                        cyc_r    <= cyc_r + CYC_ONE;
                    end
                end
                ST_READ_HI: begin
                    cam_rclk <= 1'b0;
                    state_r  <= ST_READ_LO;
                end
                ST_READ_LO: begin
                    // A full cycle has passed since the rclk rise, so the
                    // FIFO output is settled.
                    m_data  <= cam_data;
                    m_valid <= 1'b1;
                    m_sof   <= (byte_cnt_r == CNT_ZERO);
                    m_eof   <= (byte_cnt_r == LAST_BYTE);
                    state_r <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_sof   <= 1'b0;
                        m_eof   <= 1'b0;
                        if (byte_cnt_r == LAST_BYTE) begin
                            frame_done <= 1'b1;
                            state_r    <= ST_DONE;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + CNT_ONE;
                            cam_rclk   <= 1'b1;
                            state_r    <= ST_READ_HI;
                        end
                    end
                end
                ST_DONE: begin
                    cam_oe_n <= 1'b1;
`ifdef OV7670_FIFO_CTRL_CONTINUOUS_EN
                    state_r  <= ST_ARM;
`else
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
`endif
                end
                default: begin
                    cam_we     <= 1'b0;
                    cam_wrst_n <= 1'b1;
                    cam_rrst_n <= 1'b1;
                    cam_oe_n   <= 1'b1;
                    cam_rclk   <= 1'b0;
                    m_valid    <= 1'b0;
                    m_sof      <= 1'b0;
                    m_eof      <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_fifo_ctrl.sv
// Directed bench for ov7670_fifo_ctrl with an 8-byte frame. A small AL422B
// read-side model returns 0x10 + read index after each read-pointer reset.
module tb_ov7670_fifo_ctrl;

    logic       clk25;
    logic       reset_n;
    logic       capture_start;
    logic       cam_vsync;
    logic [7:0] cam_data;
    logic       cam_we;
    logic       cam_wrst_n;
    logic       cam_rrst_n;
    logic       cam_oe_n;
    logic       cam_rclk;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_sof;
    logic       m_eof;
    logic       busy;
    logic       frame_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state, sampled on the active edge with pre-edge values.
    logic [9:0] log_q[$];
    int         wrst_low_cnt  = 0;
    int         rrst_rise_cnt = 0;
    int         fd_cnt        = 0;
    int         busy_low_cnt  = 0;
    int         rise_cnt      = 0;
    logic       prev_rclk     = 1'b0;
    int         rd_ptr        = 0;

    ov7670_fifo_ctrl #(
        .FRAME_BYTES (8),
        .WRST_CYCLES (4),
        .RRST_CYCLES (4)
    ) dut (
        .clk25         (clk25),
        .reset_n       (reset_n),
        .capture_start (capture_start),
        .cam_vsync     (cam_vsync),
        .cam_data      (cam_data),
        .cam_we        (cam_we),
        .cam_wrst_n    (cam_wrst_n),
        .cam_rrst_n    (cam_rrst_n),
        .cam_oe_n      (cam_oe_n),
        .cam_rclk      (cam_rclk),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_sof         (m_sof),
        .m_eof         (m_eof),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    // 25 MHz clock.
    initial clk25 = 1'b0;
    always #20 clk25 = ~clk25;

    // FIFO read-side model and event monitor.
    initial cam_data = 8'h00;
    always @(posedge clk25) begin
        if (cam_rclk && !prev_rclk) begin
            if (!cam_rrst_n) begin
                rd_ptr = 0;
                rrst_rise_cnt++;
            end else begin
                cam_data <= 8'(8'h10 + rd_ptr);
                rd_ptr++;
            end
        end
        prev_rclk = cam_rclk;
        if (!cam_wrst_n) wrst_low_cnt++;
        if (frame_done) fd_cnt++;
        if (!busy) busy_low_cnt++;
        if (dut.vs_rise_s) rise_cnt++;
        if (m_valid && m_ready) log_q.push_back({m_sof, m_eof, m_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk25);
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return !cam_wrst_n;
            1:       return cam_we;
            2:       return !cam_we;
            3:       return frame_done;
            4:       return m_valid;
            5:       return m_valid && (m_data == 8'h12);
            6:       return m_valid && (m_data == 8'h15);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [9:0] exp_byte(input int i);
        logic [7:0] d;
        d = 8'(8'h10 + i);
        return {(i == 0), (i == 7), d};
    endfunction

    task automatic wait_for(input int sel, input string tag);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (sig(sel)) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    // Raise vsync for 3 cycles and measure edges until the selected event.
    task automatic vs_latency(input int sel, input string tag, input int exp_n);
        int n;
        n = 0;
        cam_vsync = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 3) cam_vsync = 1'b0;
            if (sig(sel)) begin
                n = i;
                break;
            end
        end
        cam_vsync = 1'b0;
        chk(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic vsync_pulse(input int n);
        cam_vsync = 1'b1;
        repeat (n) tick();
        cam_vsync = 1'b0;
    endtask

    task automatic start_capture();
        capture_start = 1'b1;
        tick();
        capture_start = 1'b0;
    endtask

    task automatic do_frame(input string tag);
        vsync_pulse(3);
        wait_for(1, "we_on");
        repeat (5) tick();
        vsync_pulse(3);
        wait_for(3, tag);
    endtask

    task automatic check_frame(input string tag, input int start);
        for (int i = 0; i < 8; i++) chk(tag, 32'(log_q[start + i]), 32'(exp_byte(i)));
    endtask

    task automatic clear_mon();
        log_q.delete();
        wrst_low_cnt  = 0;
        rrst_rise_cnt = 0;
        fd_cnt        = 0;
        busy_low_cnt  = 0;
        rise_cnt      = 0;
    endtask

    // {we, wrst_n, rrst_n, oe_n, rclk, valid, sof, eof, busy, frame_done, data}
    function automatic logic [17:0] outs();
        return {cam_we, cam_wrst_n, cam_rrst_n, cam_oe_n, cam_rclk,
                m_valid, m_sof, m_eof, busy, frame_done, m_data};
    endfunction

    localparam logic [17:0] RST_OUTS = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
                                        1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    // Directed test sequence.
    initial begin
        reset_n       = 1'b0;
        capture_start = 1'b0;
        cam_vsync     = 1'b0;
        m_ready       = 1'b1;
        repeat (3) tick();
        chk("reset_outs", 32'(outs()), 32'(RST_OUTS));
        reset_n = 1'b1;
        repeat (2) tick();

`ifndef OV7670_FIFO_CTRL_CONTINUOUS_EN
        // Basic frame with timing of the FIFO control pins.
        clear_mon();
        start_capture();
        chk("busy_rise", 32'(busy), 32'd1);
        vs_latency(0, "vs_to_wrst", 4);
        wait_for(1, "we_on");
        chk("wrst_len", 32'(wrst_low_cnt), 32'd4);
        repeat (10) tick();
        vs_latency(2, "vs_to_we_off", 4);
        wait_for(3, "done1");
        tick();
        chk("busy_fall", 32'(busy), 32'd0);
        chk("rrst_periods", 32'(rrst_rise_cnt), 32'd4);
        chk("fd_cnt1", 32'(fd_cnt), 32'd1);
        chk("oe_off", 32'(cam_oe_n), 32'd1);
        chk("len1", 32'(log_q.size()), 32'd8);
        check_frame("byte1", 0);

        // Backpressure on byte 3.
        clear_mon();
        start_capture();
        vsync_pulse(3);
        wait_for(1, "we_on2");
        repeat (5) tick();
        vsync_pulse(3);
        wait_for(5, "reach_b2");
        tick();
        m_ready = 1'b0;
        wait_for(4, "reach_b3");
        for (int i = 0; i < 5; i++) begin
            chk("stall", 32'({m_valid, cam_rclk, m_data}), 32'({1'b1, 1'b0, 8'h13}));
            tick();
        end
        m_ready = 1'b1;
        wait_for(3, "done2");
        tick();
        chk("len2", 32'(log_q.size()), 32'd8);
        check_frame("byte2", 0);

        // capture_start during WRITE and READ is ignored.
        clear_mon();
        start_capture();
        vsync_pulse(3);
        wait_for(1, "we_on3");
        start_capture();
        repeat (4) tick();
        vsync_pulse(3);
        wait_for(4, "valid3");
        start_capture();
        wait_for(3, "done3");
        repeat (60) tick();
        chk("busy_idle3", 32'(busy), 32'd0);
        chk("fd_cnt3", 32'(fd_cnt), 32'd1);
        chk("len3", 32'(log_q.size()), 32'd8);
        check_frame("byte3", 0);

        // Reset in HOLD of byte 5, then a clean restart.
        clear_mon();
        start_capture();
        vsync_pulse(3);
        wait_for(1, "we_on4");
        repeat (5) tick();
        vsync_pulse(3);
        wait_for(6, "reach_b5");
        #5;
        reset_n = 1'b0;
        #1;
        chk("mid_reset", 32'(outs()), 32'(RST_OUTS));
        tick();
        reset_n = 1'b1;
        tick();
        clear_mon();
        start_capture();
        do_frame("done4");
        tick();
        chk("len4", 32'(log_q.size()), 32'd8);
        check_frame("byte4", 0);

        // Vsync glitch versus a clean 3-cycle pulse while idle.
        repeat (5) tick();
        rise_cnt  = 0;
        cam_vsync = 1'b1;
        tick();
        cam_vsync = 1'b0;
        repeat (6) tick();
        chk("glitch_le1", 32'(rise_cnt <= 1), 32'd1);
        rise_cnt = 0;
        vsync_pulse(3);
        repeat (6) tick();
        chk("pulse3_one", 32'(rise_cnt), 32'd1);
        chk("glitch_idle", 32'(busy), 32'd0);
`else
        // Continuous capture: three frames from one capture_start.
        clear_mon();
        start_capture();
        busy_low_cnt = 0;
        for (int f = 0; f < 3; f++) do_frame("cont_done");
        repeat (3) tick();
        chk("cont_fd", 32'(fd_cnt), 32'd3);
        chk("cont_len", 32'(log_q.size()), 32'd24);
        chk("cont_busy", 32'(busy), 32'd1);
        chk("cont_busy_low", 32'(busy_low_cnt), 32'd0);
        for (int f = 0; f < 3; f++) check_frame("cont_byte", 8 * f);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
